// File: rtl/ama_riscv_br_resolve_pkg.sv
// ama_riscv_br_resolve_pkg: shared branch direction and predictor-update types
package ama_riscv_br_resolve_pkg;
  typedef enum logic {
    B_NT = 1'b0,
    B_T  = 1'b1
  } branch_t;
  typedef struct packed {
    logic resolve;
  } bp_spec_t;
  typedef struct packed {
    logic [31:0] pc_dec;
    logic [31:0] pc_exe;
    branch_t     br_res;
    bp_spec_t    spec;
  } bp_t;
endpackage

// File: rtl/ama_riscv_sat_cnt.sv
// ama_riscv_sat_cnt: enable-increment counter that sticks at all-ones, sync active-low clear
module ama_riscv_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt
);
  // count up on enable, hold once every bit is set
  always_ff @(posedge clk)
    cnt <= !rst_n ? '0 : (en && !(&cnt)) ? cnt + W'(1) : cnt;
endmodule

// File: rtl/ama_riscv_br_resolve.sv
// ama_riscv_br_resolve: DEC->EXE branch register, mispredict detection, redirect and profiling counters
module ama_riscv_br_resolve
  import ama_riscv_br_resolve_pkg::*;
#(
  parameter int ARCH_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_exe,
  input  logic              dec_vld,
  input  logic              dec_is_br,
  input  logic [ARCH_W-1:0] dec_pc,
  input  logic              dec_pred,
  input  logic [ARCH_W-1:0] dec_tgt,
  input  logic              exe_br_res,
  output logic              resolve,
  output logic [ARCH_W-1:0] pc_exe,
  output logic              br_res,
  output logic              mispred,
  output logic [ARCH_W-1:0] redir_pc,
  output logic              flush,
  output logic [CNT_W-1:0]  cnt_br,
  output logic [CNT_W-1:0]  cnt_mp
);
  logic              vld;
  logic              pred;
  logic [ARCH_W-1:0] pc;
  logic [ARCH_W-1:0] tgt;
  // capture the DEC branch unless stalled; a branch behind a mispredict is wrong-path and lands invalid
  always_ff @(posedge clk)
    if (!rst_n) begin
      vld  <= 1'b0;
      pc   <= '0;
      tgt  <= '0;
      pred <= B_NT;
    end else if (!stall_exe) begin
      vld  <= dec_vld & dec_is_br & !mispred;
      pc   <= dec_pc;
      pred <= dec_pred;
      tgt  <= dec_tgt;
    end
  // resolve once on the first unstalled cycle; redirect to the path actually taken
  always_comb begin
    resolve  = vld & !stall_exe;
    mispred  = resolve & (pred != exe_br_res);
    flush    = mispred;
    redir_pc = (exe_br_res == B_T) ? tgt : pc + ARCH_W'(4);
    pc_exe   = pc;
    br_res   = exe_br_res;
  end
  ama_riscv_sat_cnt #(.W(CNT_W)) u_cnt_br (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (resolve),
    .cnt   (cnt_br)
  );
  ama_riscv_sat_cnt #(.W(CNT_W)) u_cnt_mp (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (mispred),
    .cnt   (cnt_mp)
  );
endmodule

// File: tb/tb_ama_riscv_br_resolve.sv
// tb_ama_riscv_br_resolve: scoreboard bench for branch resolve, squash, stall, wrap, saturation and reset
module tb_ama_riscv_br_resolve;
  localparam int CNT_W = 4;
  logic             clk = 1'b0;
  logic             rst_n;
  logic             stall_exe;
  logic             dec_vld;
  logic             dec_is_br;
  logic [31:0]      dec_pc;
  logic             dec_pred;
  logic [31:0]      dec_tgt;
  logic             exe_br_res;
  logic             resolve;
  logic [31:0]      pc_exe;
  logic             br_res;
  logic             mispred;
  logic [31:0]      redir_pc;
  logic             flush;
  logic [CNT_W-1:0] cnt_br;
  logic [CNT_W-1:0] cnt_mp;

  ama_riscv_br_resolve #(.ARCH_W(32), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall_exe  (stall_exe),
    .dec_vld    (dec_vld),
    .dec_is_br  (dec_is_br),
    .dec_pc     (dec_pc),
    .dec_pred   (dec_pred),
    .dec_tgt    (dec_tgt),
    .exe_br_res (exe_br_res),
    .resolve    (resolve),
    .pc_exe     (pc_exe),
    .br_res     (br_res),
    .mispred    (mispred),
    .redir_pc   (redir_pc),
    .flush      (flush),
    .cnt_br     (cnt_br),
    .cnt_mp     (cnt_mp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        pred;
    logic [31:0] tgt;
    logic        act;
  } br_rec_t;

  br_rec_t          sb[$];
  int               errs = 0;
  int               checks = 0;
  logic [CNT_W-1:0] m_br = '0;
  logic [CNT_W-1:0] m_mp = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one clock of stimulus; act is the outcome the DEC branch will see when it reaches EXE
  task automatic cyc(input logic v, input logic br, input logic [31:0] pc, input logic pred,
                     input logic [31:0] tgt, input logic act, input logic stall);
    br_rec_t rec;
    logic    exp_res;
    logic    exp_mp;
    dec_vld    = v;
    dec_is_br  = br;
    dec_pc     = pc;
    dec_pred   = pred;
    dec_tgt    = tgt;
    stall_exe  = stall;
    exe_br_res = (sb.size() > 0) ? sb[0].act : 1'b0;
    @(negedge clk);
    exp_res = (sb.size() > 0) && !stall;
    exp_mp  = 1'b0;
    chk("cnt_br", 32'(cnt_br), 32'(m_br));
    chk("cnt_mp", 32'(cnt_mp), 32'(m_mp));
    chk("resolve", 32'(resolve), 32'(exp_res));
    if (exp_res) begin
      rec    = sb.pop_front();
      exp_mp = rec.pred != rec.act;
      chk("pc_exe", pc_exe, rec.pc);
      chk("br_res", 32'(br_res), 32'(rec.act));
      chk("mispred", 32'(mispred), 32'(exp_mp));
      chk("flush", 32'(flush), 32'(exp_mp));
      chk("redir_pc", redir_pc, rec.act ? rec.tgt : rec.pc + 32'd4);
      m_br = (&m_br) ? m_br : m_br + 1'b1;
      if (exp_mp) m_mp = (&m_mp) ? m_mp : m_mp + 1'b1;
    end else begin
      chk("mispred_idle", 32'(mispred), 32'd0);
      chk("flush_idle", 32'(flush), 32'd0);
    end
    if (!stall && v && br && !exp_mp) begin
      rec.pc   = pc;
      rec.pred = pred;
      rec.tgt  = tgt;
      rec.act  = act;
      sb.push_back(rec);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    dec_vld    = 1'b0;
    dec_is_br  = 1'b0;
    dec_pc     = '0;
    dec_pred   = 1'b0;
    dec_tgt    = '0;
    stall_exe  = 1'b0;
    exe_br_res = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    m_br = '0;
    m_mp = '0;
    @(negedge clk);
    chk("rst_resolve", 32'(resolve), 32'd0);
    chk("rst_mispred", 32'(mispred), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_pc_exe", pc_exe, 32'd0);
    chk("rst_redir_pc", redir_pc, 32'd4);
    chk("rst_cnt_br", 32'(cnt_br), 32'd0);
    chk("rst_cnt_mp", 32'(cnt_mp), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic idle(input logic stall);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, stall);
  endtask

  initial begin
    do_reset();
    // correct taken prediction
    cyc(1'b1, 1'b1, 32'h100, 1'b1, 32'h140, 1'b1, 1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("t1_cnt_br", 32'(cnt_br), 32'd1);
    // predicted taken, actually not taken, with a wrong-path branch behind it
    cyc(1'b1, 1'b1, 32'h200, 1'b1, 32'h180, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 32'h204, 1'b1, 32'h300, 1'b1, 1'b0);
    idle(1'b0);
    chk("t3_cnt_br", 32'(cnt_br), 32'd2);
    chk("t2_cnt_mp", 32'(cnt_mp), 32'd1);
    // non-branch and invalid branch never resolve
    cyc(1'b1, 1'b0, 32'h220, 1'b1, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 32'h224, 1'b1, 32'h0, 1'b0, 1'b0);
    idle(1'b0);
    // stalled branch resolves once; its wrong prediction must not flag during the stall
    cyc(1'b1, 1'b1, 32'h300, 1'b0, 32'h340, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 32'h900, 1'b1, 32'h0, 1'b1, 1'b1);
    idle(1'b0);
    idle(1'b0);
    chk("t4_cnt_br", 32'(cnt_br), 32'd3);
    // +4 wraps at the top of the address space
    cyc(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h10, 1'b0, 1'b0);
    idle(1'b0);
    // back-to-back correct predictions drive the counter into saturation
    for (int i = 0; i < 20; i++)
      cyc(1'b1, 1'b1, 32'h1000 + 32'(i * 4), i[0], 32'h2000 + 32'(i * 8), i[0], 1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("t5_cnt_br_sat", 32'(cnt_br), 32'd15);
    // reset with counters at 5/2 and a branch parked in EXE
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b1, 32'h400 + 32'(i * 16), 1'b1, 32'h800, (i < 2) ? 1'b0 : 1'b1, 1'b0);
      idle(1'b0);
    end
    cyc(1'b1, 1'b1, 32'h500, 1'b1, 32'h600, 1'b1, 1'b0);
    idle(1'b1);
    chk("t6_cnt_br_pre", 32'(cnt_br), 32'd5);
    chk("t6_cnt_mp_pre", 32'(cnt_mp), 32'd2);
    do_reset();
    idle(1'b0);
    idle(1'b0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
